// File: rtl/clk_period_monitor.sv
// Measures rise-to-rise period and high time of an asynchronous clock/strobe in clk cycles,
// flagging out-of-tolerance periods and loss of toggling. Results are held until handshaked.
module clk_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             mismatch,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic [SYNC_STAGES-1:0] prime_p0;
  logic                   ms;
  logic                   ms_d;
  logic                   rise;
  logic                   primed;
  logic                   lo_seen;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1))
      return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic out_of_tol(input logic [CNT_W-1:0] meas,
                                      input logic [CNT_W-1:0] expv,
                                      input logic [CNT_W-1:0] t);
    logic signed [CNT_W:0] d;
    logic        [CNT_W:0] mag;
    d   = $signed({1'b0, meas}) - $signed({1'b0, expv});
    mag = d[CNT_W] ? $unsigned(-d) : $unsigned(d);
    return mag > {1'b0, t};
  endfunction

  assign ms     = sync_p0[SYNC_STAGES-1];
  assign rise   = ms & ~ms_d;
  // Synchronizer contents are reset zeros until filled, so they must not count as a seen low.
  assign primed = prime_p0[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= '0;
      prime_p0   <= '0;
      ms_d       <= 1'b0;
      state      <= IDLE;
      lo_seen    <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], mon_in};
      prime_p0 <= {prime_p0[SYNC_STAGES-2:0], 1'b1};
      ms_d     <= ms;
      case (state)
        IDLE: begin
          if (en) begin
            lo_seen <= 1'b0;
            state   <= ARM;
          end
        end
        ARM: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            if (primed && !ms)
              lo_seen <= 1'b1;
            if (rise && lo_seen) begin
              cnt   <= CNT_W'(1);
              hcnt  <= CNT_W'(1);
              state <= MEASURE;
            end
          end
        end
        MEASURE: begin
          if (!en) begin
            state <= IDLE;
          end else if (rise) begin
            period     <= cnt;
            high_time  <= hcnt;
            timeout    <= 1'b0;
            mismatch   <= out_of_tol(cnt, exp_period, tol);
            meas_valid <= 1'b1;
            state      <= HOLD;
          end else if (cnt == TIMEOUT_CNT) begin
            period     <= '0;
            high_time  <= '0;
            timeout    <= 1'b1;
            mismatch   <= 1'b1;
            meas_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            cnt  <= sat_inc(cnt, 1'b1);
            hcnt <= sat_inc(hcnt, ms);
          end
        end
        HOLD: begin
          if (meas_ready) begin
            meas_valid <= 1'b0;
            lo_seen    <= 1'b0;
            state      <= en ? ARM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
